// File: rtl/tlk2711_axil_reg_bridge_if.sv
// AXI4-Lite bundle between the PS master and the TLK2711 register bridge.
// A beat transfers on a rising edge where valid and ready are both high; a raised valid holds its payload until that edge.
interface tlk2711_axil_reg_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave turning PS register accesses into single-cycle wen/ren strobes for the TLK2711 top.
// Independent write and read FSMs; a write execute always wins the register bus over a read issue.
module tlk2711_axil_reg_bridge #(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       ps_clk,
    input  logic                       ps_rst_n,
    tlk2711_axil_reg_bridge_if.slave   s_axil,
    output logic                       o_reg_wen,
    output logic [15:0]                o_reg_waddr,
    output logic [AXIL_DATA_WIDTH-1:0] o_reg_wdata,
    output logic                       o_reg_ren,
    output logic [15:0]                o_reg_raddr,
    input  logic [AXIL_DATA_WIDTH-1:0] i_reg_rdata
);
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;

    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;
    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic [AXIL_ADDR_WIDTH-1:0] awaddr_w, araddr_w;
    assign awaddr_w = s_axil.awaddr;
    assign araddr_w = s_axil.araddr;

    w_state_e                   w_state_q, w_state_d;
    logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [15:0]                awaddr_q, awaddr_d;
    logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       wfull_q, wfull_d;
    logic                       awready_q, awready_d, wready_q, wready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       wen_q, wen_d;

    r_state_e                   r_state_q, r_state_d;
    logic [15:0]                raddr_q, raddr_d;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                       arready_q, arready_d, rvalid_q, rvalid_d;
    logic                       ren_q, ren_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       w_exec_next;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wfull_d   = wfull_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wen_d     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axil.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = awaddr_w[15:0];
                end
                if (s_axil.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil.wdata;
                    wfull_d  = &s_axil.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_EXEC;
                    wen_d     = wfull_d;
                end
            end
            W_EXEC: begin
                bvalid_d  = 1'b1;
                bresp_d   = wfull_q ? RESP_OKAY : RESP_SLVERR;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // A read strobe that would land in the write-execute cycle slips one cycle.
    assign w_exec_next = (w_state_d == W_EXEC);

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        cnt_d     = cnt_q;
        ren_d     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil.arvalid && arready_q) begin
                    raddr_d   = araddr_w[15:0];
                    r_state_d = R_ISSUE;
                    ren_d     = !w_exec_next;
                end
            end
            R_ISSUE: begin
                if (ren_q) begin
                    if (RD_LAT == 3'd0) begin
                        rdata_d   = i_reg_rdata;
                        rvalid_d  = 1'b1;
                        r_state_d = R_RESP;
                    end else begin
                        cnt_d     = 3'd1;
                        r_state_d = R_WAIT;
                    end
                end else begin
                    ren_d = !w_exec_next;
                end
            end
            R_WAIT: begin
                if (cnt_q == RD_LAT) begin
                    rdata_d   = i_reg_rdata;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            R_RESP: begin
                if (s_axil.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge ps_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wfull_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            wen_q     <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rdata_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            ren_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wfull_q   <= wfull_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wen_q     <= wen_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            ren_q     <= ren_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = RESP_OKAY;
    assign o_reg_wen      = wen_q;
    assign o_reg_waddr    = awaddr_q;
    assign o_reg_wdata    = wdata_q;
    assign o_reg_ren      = ren_q;
    assign o_reg_raddr    = raddr_q;
endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Bench for tlk2711_axil_reg_bridge: directed timing cases, then randomized traffic against a register-file model.
// Expected responses are queued at issue time and consumed by an independent monitor.
module tb_tlk2711_axil_reg_bridge;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 200;

    logic          ps_clk = 1'b0;
    logic          ps_rst_n;
    logic          o_reg_wen, o_reg_ren;
    logic [15:0]   o_reg_waddr, o_reg_raddr;
    logic [DW-1:0] o_reg_wdata, i_reg_rdata;

    tlk2711_axil_reg_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();

    tlk2711_axil_reg_bridge #(
        .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .RD_LATENCY(1)
    ) dut (
        .ps_clk(ps_clk), .ps_rst_n(ps_rst_n), .s_axil(axil),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 ps_clk = ~ps_clk;
    int cyc = 0;
    always @(posedge ps_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [79:0] exp_wr_q[$];
    logic [1:0]  exp_b_q[$];
    logic [63:0] exp_r_q[$];
    logic [15:0] exp_ren_q[$];
    logic [63:0] model_mem [logic [15:0]];
    logic [63:0] reg_store [logic [15:0]];
    int wen_cnt = 0, wen_cyc = 0, ren_cyc = 0, bv_rise_cyc = 0, rv_rise_cyc = 0;
    int ready_mode = 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [63:0] model_rd(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] store_rd(input logic [15:0] a);
        return reg_store.exists(a) ? reg_store[a] : 64'h0;
    endfunction

    // A write updates the register file only with all byte lanes; reads observe every write issued before or with them.
    function automatic void expect_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s);
        if (s == 8'hFF) begin
            model_mem[a[15:0]] = d;
            exp_wr_q.push_back({a[15:0], d});
            exp_b_q.push_back(2'b00);
        end else begin
            exp_b_q.push_back(2'b10);
        end
    endfunction

    function automatic void expect_read(input logic [AW-1:0] a);
        exp_ren_q.push_back(a[15:0]);
        exp_r_q.push_back(model_rd(a[15:0]));
    endfunction

    // ---------------- register block responder (1-cycle read latency) ----------------
    initial begin
        logic        pend;
        logic [63:0] val;
        pend = 1'b0;
        val = '0;
        i_reg_rdata = '0;
        forever begin
            @(negedge ps_clk);
            i_reg_rdata = pend ? val : {$urandom, $urandom};
            pend = 1'b0;
            if (o_reg_wen) reg_store[o_reg_waddr] = o_reg_wdata;
            if (o_reg_ren) begin
                pend = 1'b1;
                val = store_rd(o_reg_raddr);
            end
        end
    end

    // ---------------- response backpressure ----------------
    initial begin
        axil.bready = 1'b1;
        axil.rready = 1'b1;
        forever begin
            @(posedge ps_clk);
            #1;
            if (ready_mode == 0) begin
                axil.bready = ($urandom_range(0, 3) != 0);
                axil.rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        rv_prev, bv_prev, r_hold;
        logic [63:0] rdata_prev;
        logic [79:0] e;
        rv_prev = 1'b0; bv_prev = 1'b0; r_hold = 1'b0; rdata_prev = '0;
        forever begin
            @(negedge ps_clk);
            if (!ps_rst_n) begin
                rv_prev = 1'b0; bv_prev = 1'b0; r_hold = 1'b0;
            end else begin
                if (o_reg_wen) begin
                    wen_cnt++;
                    wen_cyc = cyc;
                    if (exp_wr_q.size() == 0) fail_now("reg_write", $sformatf("unexpected wen addr %0h data %0h", o_reg_waddr, o_reg_wdata));
                    else begin e = exp_wr_q.pop_front(); check("reg_write", {o_reg_waddr, o_reg_wdata}, e); end
                end
                if (o_reg_ren) begin
                    ren_cyc = cyc;
                    if (exp_ren_q.size() == 0) fail_now("reg_read_addr", $sformatf("unexpected ren addr %0h", o_reg_raddr));
                    else check("reg_read_addr", 80'(o_reg_raddr), 80'(exp_ren_q.pop_front()));
                end
                if (axil.bvalid && !bv_prev) bv_rise_cyc = cyc;
                if (axil.bvalid && axil.bready) begin
                    if (exp_b_q.size() == 0) fail_now("bresp", "unexpected write response");
                    else check("bresp", 80'(axil.bresp), 80'(exp_b_q.pop_front()));
                end
                if (axil.rvalid && !rv_prev) rv_rise_cyc = cyc;
                if (r_hold && axil.rvalid) check("rdata_stable", 80'(axil.rdata), 80'(rdata_prev));
                if (axil.rvalid && axil.rready) begin
                    check("rresp", 80'(axil.rresp), 80'(2'b00));
                    if (exp_r_q.size() == 0) fail_now("rdata", "unexpected read response");
                    else check("rdata", 80'(axil.rdata), 80'(exp_r_q.pop_front()));
                end
                bv_prev = axil.bvalid;
                rv_prev = axil.rvalid;
                r_hold = axil.rvalid && !axil.rready;
                rdata_prev = axil.rdata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync_cycle();
        @(posedge ps_clk);
        #1;
    endtask

    task automatic drive_aw(input logic [AW-1:0] a, input int dly, output int hs);
        repeat (dly) @(posedge ps_clk);
        #1;
        axil.awvalid = 1'b1;
        axil.awaddr = a;
        hs = -1;
        for (int n = 0; n < TO && hs < 0; n++) begin
            @(negedge ps_clk);
            if (axil.awready) hs = cyc;
        end
        if (hs < 0) fail_now("aw_handshake", "awready timeout");
        @(posedge ps_clk);
        #1;
        axil.awvalid = 1'b0;
        axil.awaddr = AW'($urandom);
    endtask

    task automatic drive_w(input logic [63:0] d, input logic [7:0] s, input int dly, output int hs);
        repeat (dly) @(posedge ps_clk);
        #1;
        axil.wvalid = 1'b1;
        axil.wdata = d;
        axil.wstrb = s;
        hs = -1;
        for (int n = 0; n < TO && hs < 0; n++) begin
            @(negedge ps_clk);
            if (axil.wready) hs = cyc;
        end
        if (hs < 0) fail_now("w_handshake", "wready timeout");
        @(posedge ps_clk);
        #1;
        axil.wvalid = 1'b0;
        axil.wdata = {$urandom, $urandom};
    endtask

    task automatic drive_ar(input logic [AW-1:0] a, input int dly, output int hs);
        repeat (dly) @(posedge ps_clk);
        #1;
        axil.arvalid = 1'b1;
        axil.araddr = a;
        hs = -1;
        for (int n = 0; n < TO && hs < 0; n++) begin
            @(negedge ps_clk);
            if (axil.arready) hs = cyc;
        end
        if (hs < 0) fail_now("ar_handshake", "arready timeout");
        @(posedge ps_clk);
        #1;
        axil.arvalid = 1'b0;
        axil.araddr = AW'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_dly, input int w_dly, output int aw_hs, output int w_hs);
        int ah, wh;
        expect_write(a, d, s);
        fork
            drive_aw(a, aw_dly, ah);
            drive_w(d, s, w_dly, wh);
        join
        aw_hs = ah;
        w_hs = wh;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int dly, output int hs);
        expect_read(a);
        drive_ar(a, dly, hs);
    endtask

    task automatic wait_quiet(input string name);
        bit done = 0;
        for (int n = 0; n < 4 * TO && !done; n++) begin
            @(negedge ps_clk);
            done = (exp_wr_q.size() == 0) && (exp_b_q.size() == 0) && (exp_r_q.size() == 0) &&
                   (exp_ren_q.size() == 0) && !axil.bvalid && !axil.rvalid;
        end
        check({name, "_drained"}, 80'(done), 80'(1));
    endtask

    task automatic wait_ready(input string name);
        bit up = 0;
        for (int n = 0; n < 20 && !up; n++) begin
            @(negedge ps_clk);
            up = axil.awready && axil.wready && axil.arready;
        end
        check({name, "_readies_up"}, 80'(up), 80'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int aw_hs, w_hs, ar_hs, wen0;
        logic [63:0] d;
        axil.awvalid = 0; axil.awaddr = '0; axil.wvalid = 0; axil.wdata = '0; axil.wstrb = '0;
        axil.arvalid = 0; axil.araddr = '0;
        ps_rst_n = 1'b0;
        repeat (3) @(posedge ps_clk);
        @(negedge ps_clk);
        check("rst_awready", 80'(axil.awready), 0);
        check("rst_wready", 80'(axil.wready), 0);
        check("rst_arready", 80'(axil.arready), 0);
        check("rst_bvalid", 80'(axil.bvalid), 0);
        check("rst_rvalid", 80'(axil.rvalid), 0);
        check("rst_wen", 80'(o_reg_wen), 0);
        check("rst_ren", 80'(o_reg_ren), 0);
        check("rst_waddr", 80'(o_reg_waddr), 0);
        check("rst_wdata", 80'(o_reg_wdata), 0);
        check("rst_raddr", 80'(o_reg_raddr), 0);
        check("rst_rdata", 80'(axil.rdata), 0);
        check("rst_bresp", 80'(axil.bresp), 0);
        @(posedge ps_clk);
        #1 ps_rst_n = 1'b1;
        wait_ready("post_reset");

        // Aligned write: AW and W together.
        sync_cycle();
        do_write(32'h0000_0010, 64'h1122334455667788, 8'hFF, 0, 0, aw_hs, w_hs);
        wait_quiet("aligned_write");
        check("aligned_same_cycle", 80'(w_hs), 80'(aw_hs));
        check("aligned_wen_latency", 80'(wen_cyc - aw_hs), 80'(1));
        check("aligned_bvalid_latency", 80'(bv_rise_cyc - aw_hs), 80'(2));

        // W four cycles ahead of AW.
        wen0 = wen_cnt;
        d = {$urandom, $urandom};
        expect_write(32'h0000_0018, d, 8'hFF);
        sync_cycle();
        fork
            drive_aw(32'h0000_0018, 4, aw_hs);
            drive_w(d, 8'hFF, 0, w_hs);
            begin
                @(negedge ps_clk);
                repeat (4) begin
                    @(negedge ps_clk);
                    check("w_first_wready_low", 80'(axil.wready), 0);
                end
            end
        join
        wait_quiet("w_first");
        check("w_first_gap", 80'(aw_hs - w_hs), 80'(4));
        check("w_first_wen_latency", 80'(wen_cyc - aw_hs), 80'(1));
        check("w_first_single_wen", 80'(wen_cnt - wen0), 80'(1));

        // Partial strobe: beats consumed, no register write, SLVERR.
        wen0 = wen_cnt;
        sync_cycle();
        do_write(32'h0000_0028, {$urandom, $urandom}, 8'h0F, 0, 1, aw_hs, w_hs);
        wait_quiet("partial");
        check("partial_no_wen", 80'(wen_cnt - wen0), 0);

        // Read with rready held off for 5 cycles after rvalid.
        reg_store[16'h0020] = 64'hDEADBEEF00000001;
        model_mem[16'h0020] = 64'hDEADBEEF00000001;
        axil.rready = 1'b0;
        sync_cycle();
        do_read(32'h0000_0020, 0, ar_hs);
        begin
            bit seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge ps_clk);
                seen = axil.rvalid;
            end
            check("read_rvalid_seen", 80'(seen), 80'(1));
        end
        repeat (5) @(posedge ps_clk);
        #1 axil.rready = 1'b1;
        wait_quiet("read_hold");
        check("read_ren_latency", 80'(ren_cyc - ar_hs), 80'(1));
        check("read_rvalid_latency", 80'(rv_rise_cyc - ar_hs), 80'(3));

        // Collision: write execute and read issue in the same cycle.
        reg_store[16'h0030] = 64'h0BAD0BAD0BAD0BAD;
        model_mem[16'h0030] = 64'h0BAD0BAD0BAD0BAD;
        d = 64'h5555AAAA12345678;
        expect_write(32'h0000_0030, d, 8'hFF);
        expect_read(32'h0000_0030);
        sync_cycle();
        fork
            drive_aw(32'h0000_0030, 0, aw_hs);
            drive_w(d, 8'hFF, 0, w_hs);
            drive_ar(32'h0000_0030, 0, ar_hs);
        join
        wait_quiet("collision");
        check("collision_same_cycle", 80'(ar_hs), 80'(aw_hs));
        check("collision_ren_after_wen", 80'(ren_cyc - wen_cyc), 80'(1));

        // Reset while the read waits for data.
        sync_cycle();
        do_read(32'h0000_0040, 0, ar_hs);
        @(posedge ps_clk);
        #1 ps_rst_n = 1'b0;
        exp_r_q.delete();
        repeat (3) begin
            @(negedge ps_clk);
            check("rst_mid_read_rvalid", 80'(axil.rvalid), 0);
        end
        @(posedge ps_clk);
        #1 ps_rst_n = 1'b1;
        repeat (5) begin
            @(negedge ps_clk);
            check("post_rst_rvalid", 80'(axil.rvalid), 0);
        end
        wait_ready("after_mid_reset");
        d = {$urandom, $urandom};
        reg_store[16'h0008] = d;
        model_mem[16'h0008] = d;
        sync_cycle();
        do_read(32'h0000_0008, 0, ar_hs);
        wait_quiet("read_after_reset");
        check("read_after_reset_latency", 80'(rv_rise_cyc - ar_hs), 80'(3));

        // Randomized traffic; upper address bits are junk and must be ignored.
        ready_mode = 0;
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            logic [7:0]    s;
            a = {16'($urandom), 16'($urandom_range(0, 15) * 8)};
            if ($urandom_range(0, 1) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                do_write(a, {$urandom, $urandom}, s, $urandom_range(0, 3), $urandom_range(0, 3), aw_hs, w_hs);
            end else begin
                do_read(a, $urandom_range(0, 3), ar_hs);
            end
        end
        wait_quiet("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
